wrr_arbiter: RTL and testbench
==============================

Name: wrr_arbiter

Overview:
Weighted round-robin arbiter with registered one-hot grant and a downstream ready handshake. It is the parametrised successor of the team's rr_arbiter. Each requester may hold the grant for a burst of up to weight+1 accepted beats, and the grant hands over back-to-back with no idle cycle. It sits in front of shared resources (bus port, memory bank) where requesters need unequal bandwidth shares.

Parameters:
NUM_REQS, 4, number of requesters (>=2)
WEIGHT_W, 4, width of each per-requester weight field; burst length = weight+1 beats (1..2^WEIGHT_W)
IDX_W, $clog2(NUM_REQS), width of grant index (derived; not overridden)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req_i  input  NUM_REQS  request vector; requester k holds req_i[k] until its burst is done
weight_i  input  NUM_REQS*WEIGHT_W  weight of requester k in bits [k*WEIGHT_W +: WEIGHT_W]; sampled only when k is granted
ready_i  input  1  downstream accepts the current beat
grant_o  output  NUM_REQS  registered one-hot grant; all-zero when idle
grant_valid_o  output  1  equals |grant_o
grant_idx_o  output  IDX_W  binary index of the owner; holds last value when idle
burst_last_o  output  1  high while the current beat is the owner's final credited beat (credit==0)

Behaviour:
- Reset (async assert, sync-released use): grant_o=0, grant_valid_o=0, grant_idx_o=0, burst_last_o=0, credit=0, state=IDLE, ptr=NUM_REQS-1 (first priority goes to index 0).
- Beat: any rising edge with grant_valid_o=1 and ready_i=1.
- Selection function pick(vec, ptr): first set bit scanning ptr+1, ptr+2, ... wrapping modulo NUM_REQS. ptr itself is scanned last, so a sole requester may win again.
- State IDLE: if |req_i at an edge -> owner=pick(req_i, ptr), grant registered that edge, credit=weight_i[owner], ptr=owner, state GRANT. Otherwise outputs stay zero.
- State GRANT, evaluated each edge in priority order:
  a) req_i[owner]=0: release with no beat counted, regardless of ready_i.
  b) beat and credit==0: release.
  c) beat and credit>0: credit-1, grant held.
  d) no beat: hold everything; credit is not decremented.
- Release: if |req_i_eff, where req_i_eff = req_i with the owner's bit cleared in case a), then at the same edge grant the new owner=pick(req_i_eff, ptr), load credit, and set ptr. There is no bubble. Otherwise state IDLE, grant_o=0.
- Latency: request to grant is 1 cycle from IDLE. Handover costs 0 idle cycles.
- Weight changes take effect only at the next grant of that requester.
- grant_o is never multi-hot. No combinational path from req_i or ready_i to any output.
- Weight all-ones: burst of 2^WEIGHT_W beats. Credit counter is WEIGHT_W bits and never underflows.
- Reset mid-burst: outputs drop to reset values immediately, without a clock edge. After release, arbitration restarts at index 0.

Decomposition:
- Package wrr_arbiter_pkg: state enum {IDLE, GRANT}, helper function for the index width.
- One combinational sub-module rr_pick (NUM_REQS param):
  - inputs: vec, ptr
  - outputs: onehot, idx, any
  - implemented as a double-width rotate-and-priority mask.
- The top holds the state, ptr, credit and output registers.

Test Plan:
1. rst=1 with req_i=1111 for 5 cycles -> grant_o=0000 throughout. At the first edge after rst falls -> grant_o=0001, grant_idx_o=0.
2. All weights 0, req_i=1111, ready_i=1 constant -> grant_o sequence 0001,0010,0100,1000,0001, one cycle each. No zero cycle; burst_last_o=1 every cycle.
3. w0=2, w1=0, req_i=0011, ready_i=1 -> 0001 for 3 cycles (burst_last_o only on the 3rd), then 0010 for 1 cycle, then 0001 for 3 cycles, repeating.
4. w2=3, req_i=0100, ready_i toggling 1,0,0,1,1,1 -> grant 0100 held for all 6 cycles. Release only after the 4th accepted beat; with req held, it is regranted to 0100 at that edge.
5. w0=3, req_i=0001 then dropped to 0000 after 1 beat -> grant_o=0000 at the next edge, state IDLE. A new req_i=1000 is granted one cycle later.
6. Async reset mid-burst (w1=5, 2 beats done): pulse rst between edges -> grant_o=0000 immediately. After release with req_i=0010 -> grant 0010 with a full 6-beat burst.

Source files
------------

// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Contents: arbiter state enum and the grant-index width helper.
// Imported by the interface, the picker and the arbiter top.
package wrr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
// master: requester side (drives req_i, weight_i, ready_i); slave: arbiter side.
// Grant-side signals are driven from registers only.
interface wrr_arbiter_if
    import wrr_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = idx_width(NUM_REQS)
) ();

    logic [NUM_REQS-1:0]          req_i;
    logic [NUM_REQS*WEIGHT_W-1:0] weight_i;
    logic                         ready_i;
    logic [NUM_REQS-1:0]          grant_o;
    logic                         grant_valid_o;
    logic [IDX_W-1:0]             grant_idx_o;
    logic                         burst_last_o;

    modport master (
        output req_i, weight_i, ready_i,
        input  grant_o, grant_valid_o, grant_idx_o, burst_last_o
    );

    modport slave (
        input  req_i, weight_i, ready_i,
        output grant_o, grant_valid_o, grant_idx_o, burst_last_o
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: first set bit of vec scanning ptr+1, ptr+2, ... wrapping.
// Ports: vec/ptr in; onehot/idx of the winner and any (vec non-zero) out.
// Purely combinational; ptr itself is scanned last so a sole requester can win again.
module rr_pick
    import wrr_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int IDX_W    = idx_width(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] vec,
    input  logic [IDX_W-1:0]    ptr,
    output logic [NUM_REQS-1:0] onehot,
    output logic [IDX_W-1:0]    idx,
    output logic                any
);

    logic [2*NUM_REQS-1:0] dbl;
    logic [NUM_REQS-1:0]   rot;
    logic [IDX_W:0]        shamt;
    logic [IDX_W:0]        sum;
    logic [IDX_W-1:0]      off;

    // Rotating the doubled vector right by ptr+1 puts the highest-priority
    // candidate at bit 0; shamt==NUM_REQS (ptr at the top) is the identity.
    assign shamt = {1'b0, ptr} + (IDX_W+1)'(1);
    assign dbl   = {vec, vec} >> shamt;
    assign rot   = dbl[NUM_REQS-1:0];
    assign any   = |vec;

    always_comb begin
        off = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        // Undo the rotation: winner = (ptr + 1 + off) mod NUM_REQS, at most 2N-1.
        sum = shamt + {1'b0, off};
        if (sum >= (IDX_W+1)'(NUM_REQS)) begin
            sum = sum - (IDX_W+1)'(NUM_REQS);
        end
        idx    = sum[IDX_W-1:0];
        onehot = '0;
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: owner keeps a registered one-hot grant for weight+1 beats.
// Ports: clk, rst (async, active-high), bus (slave side of wrr_arbiter_if).
// Request to grant 1 cycle from idle; handover is back-to-back; beats only count when ready_i.
module wrr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int WEIGHT_W = 4,
    localparam int IDX_W   = idx_width(NUM_REQS)
) (
    input  logic          clk,
    input  logic          rst,
    wrr_arbiter_if.slave  bus
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [NUM_REQS-1:0] grant_q, grant_d;

    logic [NUM_REQS-1:0] pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [WEIGHT_W-1:0] new_weight;
    logic                release_now;

    // When the owner drops its request its bit is already zero, so masking the
    // owner out of req_i on release is a no-op; req_i feeds the picker directly.
    rr_pick #(
        .NUM_REQS (NUM_REQS),
        .IDX_W    (IDX_W)
    ) u_pick (
        .vec    (bus.req_i),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Weight of the requester about to be granted.
    always_comb begin
        new_weight = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                new_weight = bus.weight_i[k*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        credit_d    = credit_q;
        grant_d     = grant_q;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                release_now = 1'b1;
            end
            GRANT: begin
                if (!bus.req_i[idx_q]) begin
                    release_now = 1'b1;
                end else if (bus.ready_i) begin
                    if (credit_q == '0) begin
                        release_now = 1'b1;
                    end else begin
                        credit_d = credit_q - WEIGHT_W'(1);
                    end
                end
            end
            default: ;
        endcase

        // From IDLE "release" just means arbitrate; with no requester it stays idle.
        if (release_now) begin
            if (pick_any) begin
                state_d  = GRANT;
                grant_d  = pick_onehot;
                idx_d    = pick_idx;
                ptr_d    = pick_idx;
                credit_d = new_weight;
            end else begin
                state_d  = IDLE;
                grant_d  = '0;
                credit_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= IDX_W'(NUM_REQS - 1);
            idx_q    <= '0;
            credit_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            credit_q <= credit_d;
            grant_q  <= grant_d;
        end
    end

    assign bus.grant_o       = grant_q;
    assign bus.grant_valid_o = |grant_q;
    assign bus.grant_idx_o   = idx_q;
    assign bus.burst_last_o  = (state_q == GRANT) && (credit_q == '0);

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios plus random traffic.
// Reference model tracks owner / remaining beats / priority pointer as integers.
// Outputs are sampled 1 time unit after the rising edge or between edges.
module tb_wrr_arbiter;

    localparam int NR = 4;
    localparam int WW = 4;

    logic clk = 1'b0;
    logic rst;

    wrr_arbiter_if #(.NUM_REQS(NR), .WEIGHT_W(WW)) bus ();

    wrr_arbiter #(.NUM_REQS(NR), .WEIGHT_W(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: m_rem = beats still allowed in the current burst.
    bit m_gnt;
    int m_own;
    int m_rem;
    int m_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt = 1'b0;
        m_own = 0;
        m_rem = 0;
        m_ptr = NR - 1;
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int off = 1; off <= NR; off++) begin
            if (v[(p + off) % NR]) return (p + off) % NR;
        end
        return -1;
    endfunction

    task automatic model_start(input logic [NR-1:0] v);
        int k;
        logic [WW-1:0] w;
        k = pick(v, m_ptr);
        w = bus.weight_i[k*WW +: WW];
        m_own = k;
        m_ptr = k;
        m_rem = int'(w) + 1;
        m_gnt = 1'b1;
    endtask

    // One rising edge of the specified behaviour, using the inputs as sampled.
    task automatic model_step();
        logic [NR-1:0] eff;
        bit rel;
        eff = bus.req_i;
        rel = 1'b0;
        if (!m_gnt) begin
            if (eff != '0) model_start(eff);
        end else if (!eff[m_own]) begin
            eff[m_own] = 1'b0;
            rel = 1'b1;
        end else if (bus.ready_i) begin
            m_rem--;
            if (m_rem == 0) rel = 1'b1;
        end
        if (rel) begin
            if (eff != '0) model_start(eff);
            else m_gnt = 1'b0;
        end
    endtask

    task automatic cmp_all();
        logic [NR-1:0] eg;
        eg = m_gnt ? (NR'(1) << m_own) : '0;
        chk("grant", 32'(bus.grant_o), 32'(eg));
        chk("valid", 32'(bus.grant_valid_o), 32'(m_gnt));
        chk("idx", 32'(bus.grant_idx_o), 32'(m_own));
        chk("last", 32'(bus.burst_last_o), 32'(m_gnt && (m_rem == 1)));
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        cmp_all();
        @(negedge clk);
    endtask

    // Assert reset between edges and check outputs clear without a clock edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_grant", 32'(bus.grant_o), 32'h0);
        cmp_all();
        @(posedge clk);
        #1;
        cmp_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_w(input int k, input int w);
        bus.weight_i[k*WW +: WW] = WW'(w);
    endtask

    logic [NR-1:0] seq2 [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic          rdy4 [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst          = 1'b1;
        bus.req_i    = 4'b1111;
        bus.weight_i = '0;
        bus.ready_i  = 1'b1;
        model_reset();

        // Held in reset with all requesting: no grant.
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("rst_grant", 32'(bus.grant_o), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("first_grant", 32'(bus.grant_o), 32'h1);
        chk("first_idx", 32'(bus.grant_idx_o), 32'h0);

        // Equal zero weights: one beat each, no idle cycle in between.
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_seq", 32'(bus.grant_o), 32'(seq2[i]));
            chk("rr_last", 32'(bus.burst_last_o), 32'h1);
        end

        // Unequal weights between two requesters.
        set_w(0, 2);
        set_w(1, 0);
        bus.req_i = 4'b0011;
        repeat (12) cyc();

        // Single requester with stalls; regranted to itself after its burst.
        bus.req_i = 4'b0000;
        repeat (2) cyc();
        set_w(2, 3);
        bus.req_i = 4'b0100;
        cyc();
        for (int i = 0; i < 6; i++) begin
            bus.ready_i = rdy4[i];
            cyc();
            chk("stall_hold", 32'(bus.grant_o), 32'h4);
        end
        bus.ready_i = 1'b1;

        // Owner drops its request mid-burst.
        bus.req_i = 4'b0000;
        cyc();
        set_w(0, 3);
        bus.req_i = 4'b0001;
        repeat (2) cyc();
        bus.req_i = 4'b0000;
        cyc();
        chk("drop_idle", 32'(bus.grant_o), 32'h0);
        bus.req_i = 4'b1000;
        cyc();
        chk("drop_regrant", 32'(bus.grant_o), 32'h8);

        // Async reset mid-burst, then a full burst from a clean start.
        bus.req_i = 4'b0000;
        cyc();
        set_w(1, 5);
        bus.req_i = 4'b0010;
        repeat (3) cyc();
        async_reset();
        repeat (8) cyc();

        // Random traffic: sticky requests, random stalls, occasional all-ones weight.
        for (int it = 0; it < 3000; it++) begin
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(7) == 0) bus.req_i[k] = ~bus.req_i[k];
                if ($urandom_range(7) == 0) set_w(k, 15);
                else if ($urandom_range(3) == 0) set_w(k, int'($urandom_range(3)));
            end
            bus.ready_i = ($urandom_range(3) != 0);
            if ($urandom_range(199) == 0) async_reset();
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
